cnt_stream_packer: RTL and testbench
====================================

Name: cnt_stream_packer

Overview:
Sits directly downstream of the photon pulse counter. It captures each 64-bit count record (photon delta in [63:32] with trigger flag in bit 63, clock count in [31:0]), qualified by the single-cycle RDY strobe. Records are buffered in a small FIFO and serialised as two 32-bit words onto a ready/valid streaming source that feeds the HPS-side FIFO. The counter cannot be stalled, so records that arrive when the FIFO is full are dropped and counted.

Parameters:
DEPTH, 16, record FIFO depth in 64-bit entries; power of two, minimum 2
OVF_W, 16, width of the saturating dropped-record counter

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  asynchronous, active-low reset
ENABLE  in  1  1 = accept records; 0 = discard incoming records (not counted as drops); the output still drains
CNT_STREAM  in  64  record from the counter; sampled only when RDY=1
RDY  in  1  single-cycle record strobe; no backpressure possible
DOUT  out  32  stream data word
DOUT_VALID  out  1  DOUT holds a valid word
DOUT_READY  in  1  sink accepts the word when DOUT_VALID and DOUT_READY are both 1
DOUT_SOP  out  1  first word of a record (clock count, record [31:0])
DOUT_EOP  out  1  second word of a record (photon count plus flag, record [63:32])
FILL_LEVEL  out  clog2(DEPTH)+1  FIFO occupancy in records, 0..DEPTH
OVF  out  1  sticky: at least one record dropped since reset or CLR_OVF
OVF_CNT  out  OVF_W  dropped-record count; saturates at all-ones
CLR_OVF  in  1  synchronous clear of OVF and OVF_CNT

Behaviour:
- Reset (RESET=0, asynchronous): FIFO empty, state IDLE. DOUT=0, DOUT_VALID=0, DOUT_SOP=0, DOUT_EOP=0, FILL_LEVEL=0, OVF=0, OVF_CNT=0. Reset asserted mid-record discards the record and any partially sent word. After release, the first record is accepted on the next RDY.
- Push: occurs when RDY=1, ENABLE=1 and (FILL_LEVEL<DEPTH, or a pop happens in the same cycle). A pop in the same cycle frees a slot, so a full FIFO still accepts the record.
- Drop: occurs when RDY=1, ENABLE=1, FIFO full and no pop that cycle. The record is discarded, OVF is set and OVF_CNT increments, holding at 2^OVF_W-1.
- CLR_OVF=1 together with a drop in the same cycle: OVF=1 and OVF_CNT=1 (the drop wins over the clear).
- RDY=1 with ENABLE=0: the record is silently ignored.
- Output FSM has three states: IDLE, LO, HI.
  - IDLE: if the FIFO is not empty, pop the head into a 64-bit holding register and move to LO.
  - LO: DOUT=hold[31:0], SOP=1, VALID=1. On a handshake, move to HI.
  - HI: DOUT=hold[63:32], EOP=1, VALID=1. On a handshake, if the FIFO is not empty, pop the next record and go straight to LO (no bubble); otherwise go to IDLE.
- DOUT, SOP, EOP and VALID are registered. While VALID=1 and READY=0, DOUT, SOP and EOP hold stable.
- Latency: RDY in cycle N with the FIFO empty and FSM in IDLE gives VALID=1 (LO word) in cycle N+2.
- Sustained throughput is one record per 2 cycles with READY held at 1.
- FILL_LEVEL counts records in the FIFO only; the record in the holding register is excluded. It updates one cycle after a push or pop, and a simultaneous push and pop leaves it unchanged.
- Data is passed through unmodified. Bit 63 (trigger flag) is not interpreted.

Decomposition:
- Package cnt_pack_pkg holds:
  - REC_W=64 and WORD_W=32 constants;
  - the output FSM state enum (IDLE, LO, HI);
  - a helper for the FILL_LEVEL width.
- Sub-module cnt_rec_fifo: single-clock synchronous FIFO with ports push, pop, din, dout, count, full, empty. It uses show-ahead (first-word-fall-through) reads, so dout is the head record while not empty. It has the same asynchronous active-low reset.
- The top level contains the push/drop logic, the OVF counter and the output FSM.

Test Plan:
- Single record 0x8000_0005_0000_03E8 on RDY, READY=1 -> VALID in cycle N+2: DOUT=0x0000_03E8 with SOP=1, then DOUT=0x8000_0005 with EOP=1; then VALID=0; FILL_LEVEL returns to 0.
- READY=0 while 20 records arrive one per cycle (DEPTH=16) -> 1 record in the holding register, FILL_LEVEL=16, 3 dropped, OVF=1, OVF_CNT=3. Then READY=1 -> exactly 17 records emitted in order, 34 words, no bubbles.
- Full FIFO with RDY coinciding with a pop -> record accepted, FILL_LEVEL stays at 16, OVF_CNT unchanged.
- READY toggling randomly every cycle -> DOUT, SOP and EOP stable whenever VALID=1 and READY=0; word order always LO then HI per record.
- ENABLE=0 with 5 RDY strobes -> no output words, OVF_CNT=0. CLR_OVF pulsed with a simultaneous drop -> OVF_CNT=1.
- RESET asserted while in state HI with 4 records queued -> VALID=0 and FILL_LEVEL=0 immediately (asynchronously); after release, a new record emerges with latency 2 and its correct value.

Source files
------------

// File: rtl/cnt_stream_packer_pkg.sv
// Shared constants, output FSM state type and width helper for the count
// record stream packer.
package cnt_pack_pkg;

    localparam int REC_W  = 64;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_e;

    // Occupancy must represent 0..DEPTH inclusive, hence the extra bit.
    function automatic int fill_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cnt_stream_packer_if.sv
// Ready/valid 32-bit word stream with start/end-of-record markers.
interface cnt_stream_if;

    logic [cnt_pack_pkg::WORD_W-1:0] DOUT;
    logic                            DOUT_VALID;
    logic                            DOUT_READY;
    logic                            DOUT_SOP;
    logic                            DOUT_EOP;

    modport master (
        output DOUT, DOUT_VALID, DOUT_SOP, DOUT_EOP,
        input  DOUT_READY
    );

    modport slave (
        input  DOUT, DOUT_VALID, DOUT_SOP, DOUT_EOP,
        output DOUT_READY
    );

endinterface

// File: rtl/cnt_stream_packer_fifo.sv
// Single-clock show-ahead record FIFO; dout is the head entry while not empty.
module cnt_rec_fifo
    import cnt_pack_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [REC_W-1:0]         din,
    output logic [REC_W-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cnt_stream_packer.sv
// Buffers 64-bit count records and serialises each as a clock-count word
// followed by a photon-count word on a ready/valid stream; drops on overflow.
module cnt_stream_packer
    import cnt_pack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OVF_W = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       ENABLE,
    input  logic [REC_W-1:0]           CNT_STREAM,
    input  logic                       RDY,
    cnt_stream_if.master               dout_if,
    output logic [fill_w(DEPTH)-1:0]   FILL_LEVEL,
    output logic                       OVF,
    output logic [OVF_W-1:0]           OVF_CNT,
    input  logic                       CLR_OVF
);

    logic [REC_W-1:0]  fifo_dout;
    logic              fifo_full, fifo_empty;
    logic              push, pop, drop, hs, load;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] hold_hi_q, hold_hi_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              ovf_q, ovf_d;
    logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;

    cnt_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (push),
        .pop   (pop),
        .din   (CNT_STREAM),
        .dout  (fifo_dout),
        .count (FILL_LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hs   = valid_q && dout_if.DOUT_READY;
    assign load = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_HI && hs));
    assign pop  = load;
    assign push = RDY && ENABLE && (!fifo_full || pop);
    assign drop = RDY && ENABLE && fifo_full && !pop;

    always_comb begin
        state_d   = state_q;
        hold_hi_d = hold_hi_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        case (state_q)
            ST_LO: if (hs) begin
                dout_d  = hold_hi_q;
                sop_d   = 1'b0;
                eop_d   = 1'b1;
                state_d = ST_HI;
            end
            ST_HI: if (hs && fifo_empty) begin
                dout_d  = '0;
                valid_d = 1'b0;
                eop_d   = 1'b0;
                state_d = ST_IDLE;
            end
            ST_IDLE: ;
            default: state_d = ST_IDLE;
        endcase
        // The low word goes straight to the output register; only the high
        // half needs holding until the first word is accepted.
        if (load) begin
            hold_hi_d = fifo_dout[REC_W-1:WORD_W];
            dout_d    = fifo_dout[WORD_W-1:0];
            valid_d   = 1'b1;
            sop_d     = 1'b1;
            eop_d     = 1'b0;
            state_d   = ST_LO;
        end
    end

    always_comb begin
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (CLR_OVF)                 ovf_cnt_d = OVF_W'(1);
            else if (ovf_cnt_q != '1)    ovf_cnt_d = ovf_cnt_q + 1'b1;
        end else if (CLR_OVF) begin
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            hold_hi_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_hi_q <= hold_hi_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign dout_if.DOUT       = dout_q;
    assign dout_if.DOUT_VALID = valid_q;
    assign dout_if.DOUT_SOP   = sop_q;
    assign dout_if.DOUT_EOP   = eop_q;
    assign OVF                = ovf_q;
    assign OVF_CNT            = ovf_cnt_q;

endmodule

// File: tb/tb_cnt_stream_packer.sv
// Directed bench for cnt_stream_packer: latency, overflow, stalls, enable,
// overflow clear and mid-record reset.
module tb_cnt_stream_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        rdy = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [63:0] cnt_stream = '0;
    logic [4:0]  fill;
    logic        ovf;
    logic [15:0] ovf_cnt;

    int checks = 0;
    int errors = 0;

    cnt_stream_if sif();

    cnt_stream_packer #(.DEPTH(16), .OVF_W(16)) dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .ENABLE     (enable),
        .CNT_STREAM (cnt_stream),
        .RDY        (rdy),
        .dout_if    (sif),
        .FILL_LEVEL (fill),
        .OVF        (ovf),
        .OVF_CNT    (ovf_cnt),
        .CLR_OVF    (clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rec(input int i);
        logic [31:0] hi, lo;
        hi = 32'h8000_0000 + 32'h10 * 32'(i);
        lo = 32'h0000_0100 + 32'(i);
        return {hi, lo};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; enable = 1'b1; rdy = 1'b0; clr_ovf = 1'b0;
        sif.DOUT_READY = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++; if (sif.DOUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", sif.DOUT_VALID); end
        checks++; if (sif.DOUT !== 32'h0) begin errors++; $display("FAIL rst_dout got %h exp 0", sif.DOUT); end
        checks++; if ({sif.DOUT_SOP, sif.DOUT_EOP} !== 2'b00) begin errors++; $display("FAIL rst_sop_eop got %b exp 00", {sif.DOUT_SOP, sif.DOUT_EOP}); end
        checks++; if (fill !== 5'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", fill); end
        checks++; if ({ovf, ovf_cnt} !== 17'h0) begin errors++; $display("FAIL rst_ovf got %b/%0d exp 0/0", ovf, ovf_cnt); end
    endtask

    task automatic test_single;
        do_reset;
        sif.DOUT_READY = 1'b1;
        cnt_stream = 64'h8000_0005_0000_03E8; rdy = 1'b1;
        tick; rdy = 1'b0;
        checks++; if (sif.DOUT_VALID !== 1'b0) begin errors++; $display("FAIL single_n1_valid got %b exp 0", sif.DOUT_VALID); end
        checks++; if (fill !== 5'd1) begin errors++; $display("FAIL single_n1_fill got %0d exp 1", fill); end
        tick;
        checks++; if ({sif.DOUT_VALID, sif.DOUT_SOP, sif.DOUT_EOP} !== 3'b110) begin errors++; $display("FAIL single_lo_flags got %b exp 110", {sif.DOUT_VALID, sif.DOUT_SOP, sif.DOUT_EOP}); end
        checks++; if (sif.DOUT !== 32'h0000_03E8) begin errors++; $display("FAIL single_lo_dout got %h exp 000003e8", sif.DOUT); end
        checks++; if (fill !== 5'd0) begin errors++; $display("FAIL single_lo_fill got %0d exp 0", fill); end
        tick;
        checks++; if ({sif.DOUT_VALID, sif.DOUT_SOP, sif.DOUT_EOP} !== 3'b101) begin errors++; $display("FAIL single_hi_flags got %b exp 101", {sif.DOUT_VALID, sif.DOUT_SOP, sif.DOUT_EOP}); end
        checks++; if (sif.DOUT !== 32'h8000_0005) begin errors++; $display("FAIL single_hi_dout got %h exp 80000005", sif.DOUT); end
        tick;
        checks++; if (sif.DOUT_VALID !== 1'b0) begin errors++; $display("FAIL single_end_valid got %b exp 0", sif.DOUT_VALID); end
        checks++; if (fill !== 5'd0) begin errors++; $display("FAIL single_end_fill got %0d exp 0", fill); end
    endtask

    // 20 records against a stalled sink, then a push on a full FIFO that
    // coincides with a pop, then a bubble-free drain.
    task automatic test_overflow_drain;
        logic [31:0] got[$];
        logic [31:0] exp_w;
        logic [63:0] r;
        int cyc;
        do_reset;
        for (int i = 0; i < 20; i++) begin
            cnt_stream = rec(i); rdy = 1'b1;
            tick;
        end
        rdy = 1'b0;
        tick;
        checks++; if (fill !== 5'd16) begin errors++; $display("FAIL ovfl_fill got %0d exp 16", fill); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovfl_flag got %b exp 1", ovf); end
        checks++; if (ovf_cnt !== 16'd3) begin errors++; $display("FAIL ovfl_cnt got %0d exp 3", ovf_cnt); end
        r = rec(0);
        checks++; if ({sif.DOUT_VALID, sif.DOUT_SOP, sif.DOUT} !== {2'b11, r[31:0]}) begin errors++; $display("FAIL ovfl_head got %b%b %h exp 11 %h", sif.DOUT_VALID, sif.DOUT_SOP, sif.DOUT, r[31:0]); end
        sif.DOUT_READY = 1'b1;
        tick;
        checks++; if ({sif.DOUT_EOP, sif.DOUT} !== {1'b1, r[63:32]}) begin errors++; $display("FAIL ovfl_head_hi got %b %h exp 1 %h", sif.DOUT_EOP, sif.DOUT, r[63:32]); end
        cnt_stream = 64'hDEAD_BEEF_CAFE_F00D; rdy = 1'b1;
        tick;
        rdy = 1'b0;
        checks++; if (fill !== 5'd16) begin errors++; $display("FAIL fullpop_fill got %0d exp 16", fill); end
        checks++; if (ovf_cnt !== 16'd3) begin errors++; $display("FAIL fullpop_cnt got %0d exp 3", ovf_cnt); end
        cyc = 0;
        while (cyc < 100 && got.size() < 34) begin
            if (sif.DOUT_VALID) begin
                checks++; if ({sif.DOUT_SOP, sif.DOUT_EOP} !== ((got.size() % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL drain_marks word %0d got %b%b", got.size(), sif.DOUT_SOP, sif.DOUT_EOP); end
                got.push_back(sif.DOUT);
            end
            tick;
            cyc++;
        end
        checks++; if (cyc !== 34) begin errors++; $display("FAIL drain_cycles got %0d exp 34", cyc); end
        for (int k = 0; k < got.size(); k++) begin
            r = (k / 2 < 16) ? rec(k / 2 + 1) : 64'hDEAD_BEEF_CAFE_F00D;
            exp_w = (k % 2 == 0) ? r[31:0] : r[63:32];
            checks++; if (got[k] !== exp_w) begin errors++; $display("FAIL drain_word %0d got %h exp %h", k, got[k], exp_w); end
        end
        checks++; if ({sif.DOUT_VALID, fill} !== 6'd0) begin errors++; $display("FAIL drain_end got %b/%0d exp 0/0", sif.DOUT_VALID, fill); end
    endtask

    task automatic test_random_ready;
        logic [31:0] got[$];
        logic [31:0] p_dout, exp_w;
        logic        p_valid, p_ready, p_sop, p_eop;
        logic [63:0] r;
        int cyc;
        do_reset;
        p_valid = 1'b0; p_ready = 1'b0; p_dout = '0; p_sop = 1'b0; p_eop = 1'b0;
        cyc = 0;
        while (cyc < 400 && got.size() < 12) begin
            if (p_valid && !p_ready) begin
                checks++; if ({sif.DOUT_VALID, sif.DOUT, sif.DOUT_SOP, sif.DOUT_EOP} !== {1'b1, p_dout, p_sop, p_eop}) begin errors++; $display("FAIL stall_hold got %b %h %b%b exp 1 %h %b%b", sif.DOUT_VALID, sif.DOUT, sif.DOUT_SOP, sif.DOUT_EOP, p_dout, p_sop, p_eop); end
            end
            sif.DOUT_READY = 1'($urandom_range(0, 1));
            if (cyc < 6) begin cnt_stream = rec(100 + cyc); rdy = 1'b1; end
            else rdy = 1'b0;
            if (sif.DOUT_VALID && sif.DOUT_READY) begin
                checks++; if ({sif.DOUT_SOP, sif.DOUT_EOP} !== ((got.size() % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rand_marks word %0d got %b%b", got.size(), sif.DOUT_SOP, sif.DOUT_EOP); end
                got.push_back(sif.DOUT);
            end
            p_valid = sif.DOUT_VALID; p_ready = sif.DOUT_READY;
            p_dout = sif.DOUT; p_sop = sif.DOUT_SOP; p_eop = sif.DOUT_EOP;
            tick;
            cyc++;
        end
        rdy = 1'b0;
        checks++; if (got.size() !== 12) begin errors++; $display("FAIL rand_count got %0d exp 12", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            r = rec(100 + k / 2);
            exp_w = (k % 2 == 0) ? r[31:0] : r[63:32];
            checks++; if (got[k] !== exp_w) begin errors++; $display("FAIL rand_word %0d got %h exp %h", k, got[k], exp_w); end
        end
    endtask

    task automatic test_enable_clr;
        do_reset;
        enable = 1'b0;
        sif.DOUT_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rdy = (i < 10) && (i % 2 == 0);
            cnt_stream = rec(50 + i);
            tick;
            checks++; if (sif.DOUT_VALID !== 1'b0) begin errors++; $display("FAIL en_valid cyc %0d got %b exp 0", i, sif.DOUT_VALID); end
        end
        rdy = 1'b0;
        checks++; if ({ovf, ovf_cnt, fill} !== 22'h0) begin errors++; $display("FAIL en_state got %b/%0d/%0d exp 0/0/0", ovf, ovf_cnt, fill); end
        enable = 1'b1;
        sif.DOUT_READY = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cnt_stream = rec(60 + i); rdy = 1'b1;
            tick;
        end
        rdy = 1'b0;
        tick;
        checks++; if ({fill, ovf, ovf_cnt} !== {5'd16, 1'b0, 16'd0}) begin errors++; $display("FAIL clr_full got %0d/%b/%0d exp 16/0/0", fill, ovf, ovf_cnt); end
        rdy = 1'b1;
        tick;
        checks++; if ({ovf, ovf_cnt} !== {1'b1, 16'd1}) begin errors++; $display("FAIL clr_drop1 got %b/%0d exp 1/1", ovf, ovf_cnt); end
        clr_ovf = 1'b1;
        tick;
        rdy = 1'b0;
        checks++; if ({ovf, ovf_cnt} !== {1'b1, 16'd1}) begin errors++; $display("FAIL clr_with_drop got %b/%0d exp 1/1", ovf, ovf_cnt); end
        tick;
        clr_ovf = 1'b0;
        checks++; if ({ovf, ovf_cnt} !== 17'h0) begin errors++; $display("FAIL clr_only got %b/%0d exp 0/0", ovf, ovf_cnt); end
    endtask

    task automatic test_reset_mid_record;
        logic [63:0] r;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            cnt_stream = rec(200 + i); rdy = 1'b1;
            tick;
        end
        rdy = 1'b0;
        tick;
        sif.DOUT_READY = 1'b1;
        tick;
        sif.DOUT_READY = 1'b0;
        checks++; if ({sif.DOUT_VALID, sif.DOUT_EOP, fill} !== {2'b11, 5'd4}) begin errors++; $display("FAIL mid_pre got %b%b/%0d exp 11/4", sif.DOUT_VALID, sif.DOUT_EOP, fill); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({sif.DOUT_VALID, sif.DOUT_EOP, fill} !== 7'd0) begin errors++; $display("FAIL mid_async got %b%b/%0d exp 00/0", sif.DOUT_VALID, sif.DOUT_EOP, fill); end
        tick;
        rst_n = 1'b1;
        sif.DOUT_READY = 1'b1;
        r = rec(300);
        cnt_stream = r; rdy = 1'b1;
        tick;
        rdy = 1'b0;
        checks++; if (sif.DOUT_VALID !== 1'b0) begin errors++; $display("FAIL post_n1_valid got %b exp 0", sif.DOUT_VALID); end
        tick;
        checks++; if ({sif.DOUT_VALID, sif.DOUT_SOP, sif.DOUT} !== {2'b11, r[31:0]}) begin errors++; $display("FAIL post_lo got %b%b %h exp 11 %h", sif.DOUT_VALID, sif.DOUT_SOP, sif.DOUT, r[31:0]); end
        tick;
        checks++; if ({sif.DOUT_VALID, sif.DOUT_EOP, sif.DOUT} !== {2'b11, r[63:32]}) begin errors++; $display("FAIL post_hi got %b%b %h exp 11 %h", sif.DOUT_VALID, sif.DOUT_EOP, sif.DOUT, r[63:32]); end
        tick;
        checks++; if (sif.DOUT_VALID !== 1'b0) begin errors++; $display("FAIL post_end got %b exp 0", sif.DOUT_VALID); end
    endtask

    initial begin
        sif.DOUT_READY = 1'b0;
        test_reset;
        test_single;
        test_overflow_drain;
        test_random_ready;
        test_enable_clr;
        test_reset_mid_record;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
